// File: rtl/instruction_fetch_stage.sv
// -----------------------------------------------------------------------------
// instruction_fetch_stage
//
// IF stage of a 5-stage MIPS32 pipeline; its registered outputs feed IF_ID.
// Owns the PC, issues fetches on a req/ready instruction-memory port and
// presents one instruction per cycle when memory answers with zero wait.
// Handles hazard-unit stalls and branch/jump redirects.
//
// Optional feature macro: IF_MISALIGN_TRAP_EN
//   defined   : a redirect whose target has non-zero low bits traps to
//               EXC_VECTOR and raises Fetch_Exception_IF for one cycle with
//               PC_Plus_4_IF carrying the faulting target (EPC capture).
//   undefined : target low bits are forced to 00, Fetch_Exception_IF is 0.
//
// Ports
//   Clk                 in   pipeline clock, rising edge
//   Reset               in   asynchronous, active-high reset
//   Stall_IF            in   hold IF outputs, accept no new instruction
//   Redirect            in   branch/jump taken (1-cycle pulse)
//   Redirect_Target     in   new PC, sampled when Redirect=1
//   Imem_Req            out  fetch request (only in REQ)
//   Imem_Addr           out  fetch address (= PC, combinational)
//   Imem_Ready          in   transfer completes when Imem_Req & Imem_Ready
//   Imem_Rdata          in   instruction, valid in the transfer cycle
//   Instruction_IF      out  fetched instruction (NOP_INSTR when not valid)
//   PC_Plus_4_IF        out  address of fetched instruction + 4
//   Valid_IF            out  Instruction_IF is a real, right-path instruction
//   Fetch_Exception_IF  out  misaligned-fetch flag
//   Fsm_State_Dbg       out  current FSM state (0 IDLE, 1 REQ, 2 HOLD)
//
// Handshake: a memory transfer happens in exactly the cycle where
// Imem_Req=1 and Imem_Ready=1; while Imem_Req=1 and Imem_Ready=0 the
// address is held stable. The IF_ID consumer takes the outputs in any cycle
// where Stall_IF=0.
// -----------------------------------------------------------------------------
module instruction_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0180
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Stall_IF,
  input  logic        Redirect,
  input  logic [31:0] Redirect_Target,
  output logic        Imem_Req,
  output logic [31:0] Imem_Addr,
  input  logic        Imem_Ready,
  input  logic [31:0] Imem_Rdata,
  output logic [31:0] Instruction_IF,
  output logic [31:0] PC_Plus_4_IF,
  output logic        Valid_IF,
  output logic        Fetch_Exception_IF,
  output logic [1:0]  Fsm_State_Dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        pend_q, pend_d;          // redirect arrived while a fetch was waiting
  logic [31:0] pend_tgt_q, pend_tgt_d;
  logic [31:0] hold_instr_q, hold_instr_d;
  logic [31:0] hold_pc4_q, hold_pc4_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;

  logic        xfer;
  logic [31:0] pc_plus_4;
  logic [31:0] redirect_pc;

`ifdef IF_MISALIGN_TRAP_EN
  logic        exc_q, exc_d;
  logic        trap;

  assign trap        = Redirect && (Redirect_Target[1:0] != 2'b00);
  assign redirect_pc = trap ? EXC_VECTOR : Redirect_Target;
`else
  logic        unused_cfg;

  // Low target bits are meaningless without the trap; EXC_VECTOR is only
  // consumed by the trap path.
  assign redirect_pc = {Redirect_Target[31:2], 2'b00};
  assign unused_cfg  = ^{EXC_VECTOR, Redirect_Target[1:0]};
`endif

  assign xfer      = (state_q == S_REQ) && Imem_Ready;
  assign pc_plus_4 = pc_q + 32'd4;   // wraps modulo 2^32

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    pend_d       = pend_q;
    pend_tgt_d   = pend_tgt_q;
    hold_instr_d = hold_instr_q;
    hold_pc4_d   = hold_pc4_q;
    instr_d      = instr_q;
    pc4_d        = pc4_q;
    valid_d      = valid_q;
`ifdef IF_MISALIGN_TRAP_EN
    exc_d        = 1'b0;
`endif

    case (state_q)
      S_IDLE: begin
        state_d = S_REQ;
        if (Redirect) pc_d = redirect_pc;
      end

      S_REQ: begin
        if (Redirect) begin
          if (xfer) begin
            // Data in this cycle is wrong-path; jump straight away.
            pc_d   = redirect_pc;
            pend_d = 1'b0;
          end else begin
            // Address must stay stable while the fetch waits, so the new
            // target (trap vector included) is parked until the transfer.
            // A newer redirect simply overwrites the parked target.
            pend_d     = 1'b1;
            pend_tgt_d = redirect_pc;
          end
        end else if (pend_q) begin
          if (xfer) begin
            pc_d   = pend_tgt_q;
            pend_d = 1'b0;
          end
          if (!Stall_IF) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
          end
        end else if (xfer) begin
          if (Stall_IF) begin
            // Consumer cannot take it: park the word and stop fetching.
            hold_instr_d = Imem_Rdata;
            hold_pc4_d   = pc_plus_4;
            state_d      = S_HOLD;
          end else begin
            instr_d = Imem_Rdata;
            pc4_d   = pc_plus_4;
            valid_d = 1'b1;
            pc_d    = pc_plus_4;
          end
        end else if (!Stall_IF) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      S_HOLD: begin
        if (Redirect) begin
          pc_d    = redirect_pc;
          state_d = S_REQ;
        end else if (!Stall_IF) begin
          instr_d = hold_instr_q;
          pc4_d   = hold_pc4_q;
          valid_d = 1'b1;
          pc_d    = pc_plus_4;
          state_d = S_REQ;
        end
      end

      default: state_d = S_IDLE;
    endcase

    // Anything in flight on a redirect is wrong-path: bubble, even if stalled.
    if (Redirect) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end

`ifdef IF_MISALIGN_TRAP_EN
    if (trap) begin
      exc_d  = 1'b1;
      pc4_d  = Redirect_Target;   // EPC: the faulting target itself
    end
`endif
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q      <= S_IDLE;
      pc_q         <= RESET_PC;
      pend_q       <= 1'b0;
      pend_tgt_q   <= 32'h0;
      hold_instr_q <= 32'h0;
      hold_pc4_q   <= 32'h0;
      instr_q      <= NOP_INSTR;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
`ifdef IF_MISALIGN_TRAP_EN
      exc_q        <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      pend_q       <= pend_d;
      pend_tgt_q   <= pend_tgt_d;
      hold_instr_q <= hold_instr_d;
      hold_pc4_q   <= hold_pc4_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
`ifdef IF_MISALIGN_TRAP_EN
      exc_q        <= exc_d;
`endif
    end
  end

  assign Imem_Req       = (state_q == S_REQ);
  assign Imem_Addr      = pc_q;
  assign Instruction_IF = instr_q;
  assign PC_Plus_4_IF   = pc4_q;
  assign Valid_IF       = valid_q;
  assign Fsm_State_Dbg  = state_q;
`ifdef IF_MISALIGN_TRAP_EN
  assign Fetch_Exception_IF = exc_q;
`else
  assign Fetch_Exception_IF = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_fetch_stage.sv
// Directed bench for instruction_fetch_stage. Memory returns a word derived
// from the address; every instruction that should reach IF_ID is pushed as
// {instruction, pc+4} into exp_q by the driver, and a negedge monitor pops
// and compares whenever Valid_IF=1 and Stall_IF=0.
module tb_instruction_fetch_stage;

  logic        Clk;
  logic        Reset;
  logic        Stall_IF;
  logic        Redirect;
  logic [31:0] Redirect_Target;
  logic        Imem_Req;
  logic [31:0] Imem_Addr;
  logic        Imem_Ready;
  logic [31:0] Imem_Rdata;
  logic [31:0] Instruction_IF;
  logic [31:0] PC_Plus_4_IF;
  logic        Valid_IF;
  logic        Fetch_Exception_IF;
  logic [1:0]  Fsm_State_Dbg;

  // Second instance with a wrapping reset PC.
  logic        w_req;
  logic [31:0] w_addr;
  logic [31:0] w_rdata;
  logic [31:0] w_instr;
  logic [31:0] w_pc4;
  logic        w_valid;
  logic        w_exc;
  logic [1:0]  w_state;

  logic [63:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;

  instruction_fetch_stage dut (
    .Clk(Clk), .Reset(Reset), .Stall_IF(Stall_IF), .Redirect(Redirect),
    .Redirect_Target(Redirect_Target), .Imem_Req(Imem_Req), .Imem_Addr(Imem_Addr),
    .Imem_Ready(Imem_Ready), .Imem_Rdata(Imem_Rdata), .Instruction_IF(Instruction_IF),
    .PC_Plus_4_IF(PC_Plus_4_IF), .Valid_IF(Valid_IF),
    .Fetch_Exception_IF(Fetch_Exception_IF), .Fsm_State_Dbg(Fsm_State_Dbg)
  );

  instruction_fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .Clk(Clk), .Reset(Reset), .Stall_IF(Stall_IF), .Redirect(Redirect),
    .Redirect_Target(Redirect_Target), .Imem_Req(w_req), .Imem_Addr(w_addr),
    .Imem_Ready(Imem_Ready), .Imem_Rdata(w_rdata), .Instruction_IF(w_instr),
    .PC_Plus_4_IF(w_pc4), .Valid_IF(w_valid),
    .Fetch_Exception_IF(w_exc), .Fsm_State_Dbg(w_state)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- memory model ----------------
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return {16'h2408 ^ a[31:16], a[15:0]};
  endfunction

  always_comb begin
    Imem_Rdata = instr_of(Imem_Addr);
    w_rdata    = instr_of(w_addr);
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic push(input logic [31:0] addr);
    exp_q.push_back({instr_of(addr), addr + 32'd4});
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge Clk) begin
    logic [63:0] e;
    if (!Reset && Valid_IF && !Stall_IF) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_instr actual=%h/%h required=none", Instruction_IF, PC_Plus_4_IF);
      end else begin
        e = exp_q.pop_front();
        if ({Instruction_IF, PC_Plus_4_IF} !== e) begin
          errors++;
          $display("FAIL sb_instr actual=%h/%h required=%h/%h",
                   Instruction_IF, PC_Plus_4_IF, e[63:32], e[31:0]);
        end
      end
    end
  end

  // ---------------- directed stimulus ----------------
  logic [31:0] exp_trap_addr;

  initial begin
`ifdef IF_MISALIGN_TRAP_EN
    exp_trap_addr = 32'h0000_0180;
`else
    exp_trap_addr = 32'h0000_0100;
`endif
    Reset = 1'b1; Stall_IF = 1'b0; Redirect = 1'b0;
    Redirect_Target = 32'h0; Imem_Ready = 1'b1;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_req", {31'b0, Imem_Req}, 32'd0);
    chk("rst_addr", Imem_Addr, 32'h0);
    chk("rst_instr", Instruction_IF, 32'h0);
    chk("rst_pc4", PC_Plus_4_IF, 32'h0);
    chk("rst_valid", {31'b0, Valid_IF}, 32'd0);
    chk("rst_exc", {31'b0, Fetch_Exception_IF}, 32'd0);
    chk("rst_w_addr", w_addr, 32'hFFFF_FFF8);

    Reset = 1'b0;                                 // IDLE cycle
    chk("idle_req", {31'b0, Imem_Req}, 32'd0);
    chk("idle_state", {30'b0, Fsm_State_Dbg}, 32'd0);
    step();

    // back-to-back fetch, zero wait
    chk("a_addr", Imem_Addr, 32'h0);
    chk("a_req", {31'b0, Imem_Req}, 32'd1);
    chk("a_w_addr", w_addr, 32'hFFFF_FFF8);
    push(32'h0);
    step();
    chk("b_addr", Imem_Addr, 32'h4);
    chk("b_w_addr", w_addr, 32'hFFFF_FFFC);
    chk("b_w_pc4", w_pc4, 32'hFFFF_FFFC);
    chk("b_w_valid", {31'b0, w_valid}, 32'd1);
    push(32'h4);
    step();

    // memory wait: three cycles on address 8
    chk("w_wrap_addr", w_addr, 32'h0);
    chk("w_wrap_pc4", w_pc4, 32'h0);
    chk("w_wrap_instr", w_instr, instr_of(32'hFFFF_FFFC));
    Imem_Ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("wait_addr", Imem_Addr, 32'h8);
      chk("wait_req", {31'b0, Imem_Req}, 32'd1);
      step();
      chk("wait_bubble_valid", {31'b0, Valid_IF}, 32'd0);
      chk("wait_bubble_instr", Instruction_IF, 32'h0);
    end
    Imem_Ready = 1'b1;
    chk("resume_addr", Imem_Addr, 32'h8);
    push(32'h8);
    step();
    chk("d_addr", Imem_Addr, 32'hC);
    push(32'hC);
    step();

    // stall while address 16 transfers
    chk("e_addr", Imem_Addr, 32'h10);
    push(32'h10);
    Stall_IF = 1'b1;
    step();
    chk("hold_req", {31'b0, Imem_Req}, 32'd0);
    chk("hold_state", {30'b0, Fsm_State_Dbg}, 32'd2);
    chk("hold_frozen_instr", Instruction_IF, instr_of(32'hC));
    step();
    chk("hold2_frozen_pc4", PC_Plus_4_IF, 32'h10);
    Stall_IF = 1'b0;
    step();
    chk("after_hold_addr", Imem_Addr, 32'h14);
    chk("after_hold_pc4", PC_Plus_4_IF, 32'h14);
    push(32'h14);
    step();

    // redirect while waiting on address 24
    chk("i_addr", Imem_Addr, 32'h18);
    Imem_Ready = 1'b0; Redirect = 1'b1; Redirect_Target = 32'h100;
    step();
    Redirect = 1'b0;
    chk("pend_addr_stable", Imem_Addr, 32'h18);
    chk("pend_valid", {31'b0, Valid_IF}, 32'd0);
    step();
    Imem_Ready = 1'b1;                            // discarded transfer
    chk("pend_xfer_addr", Imem_Addr, 32'h18);
    step();
    chk("redir_addr", Imem_Addr, 32'h100);
    chk("redir_valid", {31'b0, Valid_IF}, 32'd0);
    push(32'h100);
    step();
    chk("m_addr", Imem_Addr, 32'h104);
    push(32'h104);
    step();

    // redirect in the transfer cycle
    chk("n_addr", Imem_Addr, 32'h108);
    Redirect = 1'b1; Redirect_Target = 32'h200;
    step();
    chk("o_addr", Imem_Addr, 32'h200);
    chk("o_valid", {31'b0, Valid_IF}, 32'd0);

    // misaligned redirect target
    Redirect_Target = 32'h102;
    step();
    Redirect = 1'b0; Imem_Ready = 1'b0;
    chk("trap_addr", Imem_Addr, exp_trap_addr);
    chk("trap_valid", {31'b0, Valid_IF}, 32'd0);
    chk("trap_instr", Instruction_IF, 32'h0);
`ifdef IF_MISALIGN_TRAP_EN
    chk("trap_exc", {31'b0, Fetch_Exception_IF}, 32'd1);
    chk("trap_epc", PC_Plus_4_IF, 32'h102);
`else
    chk("trap_exc", {31'b0, Fetch_Exception_IF}, 32'd0);
`endif
    step();
    chk("exc_pulse_end", {31'b0, Fetch_Exception_IF}, 32'd0);

    // redirect out of HOLD overrides the stall
    Imem_Ready = 1'b1; Stall_IF = 1'b1;
    step();
    chk("r_state", {30'b0, Fsm_State_Dbg}, 32'd2);
    Redirect = 1'b1; Redirect_Target = 32'h300;
    step();
    Redirect = 1'b0; Stall_IF = 1'b0;
    chk("s_addr", Imem_Addr, 32'h300);
    chk("s_req", {31'b0, Imem_Req}, 32'd1);
    chk("s_valid", {31'b0, Valid_IF}, 32'd0);
    push(32'h300);
    step();
    Imem_Ready = 1'b0;
    repeat (4) step();
    chk("queue_drained", exp_q.size(), 32'd0);

    // reset while a request is outstanding
    chk("pre_rst_req", {31'b0, Imem_Req}, 32'd1);
    Reset = 1'b1;
    #1;
    chk("async_rst_req", {31'b0, Imem_Req}, 32'd0);
    chk("async_rst_pc4", PC_Plus_4_IF, 32'h0);
    chk("async_rst_addr", Imem_Addr, 32'h0);
    step();
    Reset = 1'b0;
    Imem_Ready = 1'b1;
    step();
    chk("post_rst_addr", Imem_Addr, 32'h0);
    chk("post_rst_req", {31'b0, Imem_Req}, 32'd1);
    Imem_Ready = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
